axi_default_slave: RTL and testbench

AXI4 responder that terminates every transaction decoded to no mapped slave and answers it with DECERR. It sits on one spare crossbar slave port, the target for addresses that fall outside every base/end window in the address map. The read and write channels are independent and run concurrently. Each channel has at most one outstanding transaction.

---
 rtl/axi_pkg.sv | 28 ++
 rtl/axi_default_slave_rd.sv | 67 ++++++
 rtl/axi_default_slave.sv | 117 +++++++++++
 tb/tb_axi_default_slave.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes, burst length width and the
// state encodings used by the default (DECERR) slave.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int AXI_LEN_WIDTH = 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Response code driven on a channel: DECERR while a response is live,
    // otherwise the bus is held at zero.
    function automatic logic [1:0] decerr_when(input logic active);
        return active ? RESP_DECERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_default_slave_rd.sv
// Read burst generator for the default slave: accepts one AR at a time and
// returns ARLEN+1 DECERR beats, the last one flagged with RLAST.
module axi_default_slave_rd
    import axi_pkg::*;
#(
    parameter int ID_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     ar_valid,
    input  logic [ID_WIDTH-1:0]      ar_id,
    input  logic [AXI_LEN_WIDTH-1:0] ar_len,
    output logic                     ar_ready,
    output logic                     r_valid,
    output logic [ID_WIDTH-1:0]      r_id,
    output logic                     r_last,
    input  logic                     r_ready
);

    rd_state_t                r_state_reg;
    logic [ID_WIDTH-1:0]      rid_reg;
    logic [AXI_LEN_WIDTH-1:0] cnt_reg;

    logic ar_hs;
    logic r_hs;
    logic active;

    assign active = (r_state_reg == R_DATA) && !srst;
    assign ar_hs  = ar_valid && ar_ready;
    assign r_hs   = r_valid && r_ready;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state_reg <= R_IDLE;
            rid_reg     <= '0;
            cnt_reg     <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_hs) begin
                        rid_reg     <= ar_id;
                        cnt_reg     <= ar_len;
                        r_state_reg <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (cnt_reg == '0) begin
                            r_state_reg <= R_IDLE;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // Everything decodes from registered state; reset forces the bus quiet
    // in the very cycle it is asserted.
    assign ar_ready = (r_state_reg == R_IDLE) && !srst;
    assign r_valid  = active;
    assign r_id     = active ? rid_reg : '0;
    assign r_last   = active && (cnt_reg == '0);

endmodule

// File: rtl/axi_default_slave.sv
// AXI4 default slave: terminates transactions that decode to no mapped
// slave. Writes and reads run independently and always answer DECERR.
module axi_default_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESET,

    input  logic [ID_WIDTH-1:0]      AWID,
    input  logic [ADDR_WIDTH-1:0]    AWADDR,
    input  logic [7:0]               AWLEN,
    input  logic [2:0]               AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic                     AWVALID,
    output logic                     AWREADY,

    input  logic [DATA_WIDTH-1:0]    WDATA,
    input  logic [DATA_WIDTH/8-1:0]  WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,

    output logic [ID_WIDTH-1:0]      BID,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,

    input  logic [ID_WIDTH-1:0]      ARID,
    input  logic [ADDR_WIDTH-1:0]    ARADDR,
    input  logic [7:0]               ARLEN,
    input  logic [2:0]               ARSIZE,
    input  logic [1:0]               ARBURST,
    input  logic                     ARVALID,
    output logic                     ARREADY,

    output logic [ID_WIDTH-1:0]      RID,
    output logic [DATA_WIDTH-1:0]    RDATA,
    output logic [1:0]               RRESP,
    output logic                     RLAST,
    output logic                     RVALID,
    input  logic                     RREADY
);

    wr_state_t           w_state_reg;
    logic [ID_WIDTH-1:0] bid_reg;

    logic aw_hs;
    logic w_last_hs;
    logic b_active;

    // Address, size, burst and write data carry no meaning for a DECERR
    // target; AWLEN is ignored because WLAST alone ends the burst.
    logic unused_inputs;
    assign unused_inputs = ^{AWADDR, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB,
                             ARADDR, ARSIZE, ARBURST};

    assign aw_hs     = AWVALID && AWREADY;
    assign w_last_hs = WVALID && WREADY && WLAST;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_reg <= W_IDLE;
            bid_reg     <= '0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_hs) begin
                        bid_reg     <= AWID;
                        w_state_reg <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_last_hs) begin
                        w_state_reg <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    assign b_active = (w_state_reg == W_RESP) && !ARESET;

    assign AWREADY = (w_state_reg == W_IDLE) && !ARESET;
    assign WREADY  = (w_state_reg == W_DATA) && !ARESET;
    assign BVALID  = b_active;
    assign BID     = b_active ? bid_reg : '0;
    assign BRESP   = decerr_when(b_active);

    axi_default_slave_rd #(
        .ID_WIDTH (ID_WIDTH)
    ) u_rd (
        .clk      (ACLK),
        .srst     (ARESET),
        .ar_valid (ARVALID),
        .ar_id    (ARID),
        .ar_len   (ARLEN),
        .ar_ready (ARREADY),
        .r_valid  (RVALID),
        .r_id     (RID),
        .r_last   (RLAST),
        .r_ready  (RREADY)
    );

    assign RDATA = '0;
    assign RRESP = decerr_when(RVALID);

endmodule

// File: tb/tb_axi_default_slave.sv
// Cycle-table bench for axi_default_slave plus a hand-written 256-beat
// read with RREADY backpressure.
module tb_axi_default_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [IW-1:0] AWID;
    logic [AW-1:0] AWADDR;
    logic [7:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic [1:0]    AWBURST;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic [DW/8-1:0] WSTRB;
    logic          WLAST;
    logic          WVALID;
    logic          WREADY;
    logic [IW-1:0] BID;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [IW-1:0] ARID;
    logic [AW-1:0] ARADDR;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          ARVALID;
    logic          ARREADY;
    logic [IW-1:0] RID;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;

    always #5 ACLK = ~ACLK;

    axi_default_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW)
    ) dut (
        .ACLK    (ACLK),    .ARESET  (ARESET),
        .AWID    (AWID),    .AWADDR  (AWADDR),  .AWLEN   (AWLEN),
        .AWSIZE  (AWSIZE),  .AWBURST (AWBURST), .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),   .WSTRB   (WSTRB),   .WLAST   (WLAST),
        .WVALID  (WVALID),  .WREADY  (WREADY),
        .BID     (BID),     .BRESP   (BRESP),   .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARID    (ARID),    .ARADDR  (ARADDR),  .ARLEN   (ARLEN),
        .ARSIZE  (ARSIZE),  .ARBURST (ARBURST), .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RID     (RID),     .RDATA   (RDATA),   .RRESP   (RRESP),
        .RLAST   (RLAST),   .RVALID  (RVALID),  .RREADY  (RREADY)
    );

    typedef struct {
        logic          rst;
        logic          awv;
        logic [IW-1:0] awid;
        logic          wv;
        logic          wl;
        logic          br;
        logic          arv;
        logic [IW-1:0] arid;
        logic [7:0]    arlen;
        logic          rr;
        logic [63:0]   exp_out;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    // Output packing: {AWREADY,WREADY,BVALID,BID,BRESP,ARREADY,RVALID,RID,RRESP,RLAST,RDATA}
    function automatic logic [63:0] pack_out(
        input logic awr, input logic wr, input logic bv, input logic [IW-1:0] bid,
        input logic [1:0] bresp, input logic arr, input logic rv,
        input logic [IW-1:0] rid, input logic [1:0] rresp, input logic rl,
        input logic [DW-1:0] rdata);
        return 64'({awr, wr, bv, bid, bresp, arr, rv, rid, rresp, rl, rdata});
    endfunction

    function automatic logic [63:0] dut_out();
        return pack_out(AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID,
                        RID, RRESP, RLAST, RDATA);
    endfunction

    // Inputs: rst awv awid wv wl br arv arid arlen rr
    // Expected: awr wr bv bid bresp arr rv rid rresp rlast (RDATA always 0)
    task automatic add(input int rst, input int awv, input int awid, input int wv,
                       input int wl, input int br, input int arv, input int arid,
                       input int arlen, input int rr,
                       input int e_awr, input int e_wr, input int e_bv, input int e_bid,
                       input int e_bresp, input int e_arr, input int e_rv, input int e_rid,
                       input int e_rresp, input int e_rl);
        vec_t v;
        v.rst   = 1'(rst);
        v.awv   = 1'(awv);
        v.awid  = IW'(awid);
        v.wv    = 1'(wv);
        v.wl    = 1'(wl);
        v.br    = 1'(br);
        v.arv   = 1'(arv);
        v.arid  = IW'(arid);
        v.arlen = 8'(arlen);
        v.rr    = 1'(rr);
        v.exp_out = pack_out(1'(e_awr), 1'(e_wr), 1'(e_bv), IW'(e_bid), 2'(e_bresp),
                             1'(e_arr), 1'(e_rv), IW'(e_rid), 2'(e_rresp), 1'(e_rl),
                             '0);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(input vec_t v);
        ARESET  = v.rst;
        AWVALID = v.awv;
        AWID    = v.awid;
        WVALID  = v.wv;
        WLAST   = v.wl;
        BREADY  = v.br;
        ARVALID = v.arv;
        ARID    = v.arid;
        ARLEN   = v.arlen;
        RREADY  = v.rr;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        logic        held_valid;
        int          beats;
        int          rlast_errs;
        int          stab_errs;

        AWADDR = 32'h1000_0000; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01;
        WDATA  = 32'hDEAD_BEEF; WSTRB = 4'hF;
        ARADDR = 32'h2000_0000; ARSIZE = 3'd2; ARBURST = 2'b01;
        ARESET = 1'b1; AWVALID = 0; AWID = 0; WVALID = 0; WLAST = 0; BREADY = 0;
        ARVALID = 0; ARID = 0; ARLEN = 0; RREADY = 0;

        //   rst awv awid wv wl br arv arid len rr | awr wr bv bid br arr rv rid rr rl
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // single read, ARLEN=0
        add(0, 0, 0, 0, 0, 0, 1, 3, 0, 1,     1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,     1, 0, 0, 0, 0, 0, 1, 3, 3, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // W presented three cycles before AW
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 5, 1, 0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 3, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0,     0, 0, 1, 5, 3, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // concurrent AW (ID 1) and AR (ID 2, ARLEN=3)
        add(0, 1, 1, 0, 0, 0, 1, 2, 3, 1,     1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1,     0, 1, 0, 0, 0, 0, 1, 2, 3, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1,     0, 0, 1, 1, 3, 0, 1, 2, 3, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,     1, 0, 0, 0, 0, 0, 1, 2, 3, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,     1, 0, 0, 0, 0, 0, 1, 2, 3, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // reset during beat 2 of an ARLEN=7 read and during W_DATA
        add(0, 1, 6, 0, 0, 0, 1, 4, 7, 1,     1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,     0, 1, 0, 0, 0, 0, 1, 4, 3, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,     0, 1, 0, 0, 0, 0, 1, 4, 3, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 0, 0, 0, 1,     1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,     1, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        repeat (2) @(posedge ACLK);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp_out);
            @(posedge ACLK);
            #1;
        end

        // 256-beat read with RREADY alternating 1/0
        ARESET = 0; AWVALID = 0; WVALID = 0; WLAST = 0; BREADY = 0;
        ARVALID = 1; ARID = 4'd9; ARLEN = 8'd255; RREADY = 0;
        #1;
        check("burst_arready", 64'(ARREADY), 64'd1);
        @(posedge ACLK);
        #1;
        ARVALID = 0;
        beats = 0; rlast_errs = 0; stab_errs = 0; held_valid = 0; held = '0;
        for (int k = 0; k < 2000; k++) begin
            RREADY = (k % 2 == 0);
            #1;
            if (held_valid && dut_out() !== held) stab_errs++;
            held_valid = 0;
            if (RVALID && (RID !== 4'd9 || RRESP !== 2'b11 || RDATA !== '0)) stab_errs++;
            if (RVALID && !RREADY) begin
                held = dut_out();
                held_valid = 1;
            end
            if (RVALID && RREADY) begin
                beats++;
                if (RLAST !== (beats == 256)) rlast_errs++;
            end
            @(posedge ACLK);
            #1;
            if (beats >= 256 && !RVALID) break;
        end
        RREADY = 0;
        #1;
        $display("burst: %0d beats, %0d rlast errors, %0d payload errors",
                 beats, rlast_errs, stab_errs);
        check("burst_beats", 64'(beats), 64'd256);
        check("burst_rlast", 64'(rlast_errs), 64'd0);
        check("burst_stable", 64'(stab_errs), 64'd0);
        check("burst_idle", 64'({ARREADY, RVALID}), 64'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
